// File: rtl/demux_pkg.sv
// Shared constants and width helpers for the round-robin demux
// and its matching lane-pointer users (mux / unstriper).
package demux_pkg;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_WORD  = 1'b1;

    // Lane-pointer width: never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Burst word counter width; MAX_BURST=0 still needs a legal vector.
    function automatic int cnt_w(input int m);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_lane_ptr.sv
// Modulo-N wrap counter used as a round-robin lane pointer.
// N need not be a power of two.
module rr_lane_ptr
    import demux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = sel_w(N)
) (
    input  logic         clk_2f,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/demux_rr_n.sv
// 1:N valid-qualified demux with round-robin lane steering,
// burst/word modes and a forced split after MAX_BURST words.
module demux_rr_n
    import demux_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int N_CH      = 4,
    parameter  int MAX_BURST = 16,
    localparam int SEL_W     = sel_w(N_CH)
) (
    input  logic                   clk_2f,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   mode_word,
    output logic [N_CH*DATA_W-1:0] data_out,
    output logic [N_CH-1:0]        valid_out,
    output logic [SEL_W-1:0]       lane_idx,
    output logic                   burst_split
);

    localparam int CNT_W = cnt_w(MAX_BURST);

    logic             mode_q;
    logic             in_burst;
    logic             in_burst_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             adv;
    logic             split_nxt;

    rr_lane_ptr #(
        .N (N_CH),
        .W (SEL_W)
    ) u_ptr (
        .clk_2f (clk_2f),
        .reset  (reset),
        .adv    (adv),
        .ptr    (lane_idx)
    );

    always_comb begin
        adv          = 1'b0;
        split_nxt    = 1'b0;
        in_burst_nxt = in_burst;
        cnt_nxt      = cnt;
        if (valid_in) begin
            if (mode_q == MODE_WORD) begin
                adv          = 1'b1;
                in_burst_nxt = 1'b0;
                cnt_nxt      = '0;
            end else if (MAX_BURST > 0 &&
                         cnt == CNT_W'(MAX_BURST - 1)) begin
                // Split consumes the burst end: no second advance on idle.
                adv          = 1'b1;
                split_nxt    = 1'b1;
                in_burst_nxt = 1'b0;
                cnt_nxt      = '0;
            end else begin
                in_burst_nxt = 1'b1;
                cnt_nxt      = (MAX_BURST > 0) ? cnt + 1'b1 : '0;
            end
        end else begin
            adv          = in_burst;
            in_burst_nxt = 1'b0;
            cnt_nxt      = '0;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_BURST;
            in_burst <= 1'b0;
            cnt      <= '0;
        end else begin
            in_burst <= in_burst_nxt;
            cnt      <= cnt_nxt;
            if (!valid_in) begin
                mode_q <= mode_word;
            end
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            data_out    <= '0;
            valid_out   <= '0;
            burst_split <= 1'b0;
        end else begin
            burst_split <= split_nxt;
            for (int k = 0; k < N_CH; k++) begin
                if (valid_in && lane_idx == SEL_W'(k)) begin
                    data_out[k*DATA_W +: DATA_W] <= data_in;
                    valid_out[k]                 <= 1'b1;
                end else begin
                    data_out[k*DATA_W +: DATA_W] <= '0;
                    valid_out[k]                 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_n.sv
// Scoreboard bench for demux_rr_n (N_CH=4, DATA_W=8, MAX_BURST=4).
// Expected lane/data/split pushed at drive time, popped one edge later.
module tb_demux_rr_n;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [NC-1:0]    v;
        logic [NC*DW-1:0] d;
        logic             s;
    } exp_t;

    logic             clk_2f = 1'b0;
    logic             reset;
    logic             valid_in;
    logic [DW-1:0]    data_in;
    logic             mode_word;
    logic [NC*DW-1:0] data_out;
    logic [NC-1:0]    valid_out;
    logic [1:0]       lane_idx;
    logic             burst_split;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    demux_rr_n #(
        .DATA_W    (DW),
        .N_CH      (NC),
        .MAX_BURST (MB)
    ) dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .mode_word   (mode_word),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_idx    (lane_idx),
        .burst_split (burst_split)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk_2f);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("valid_out", 32'(valid_out), 32'(e.v));
        chk("data_out", data_out, e.d);
        chk("burst_split", 32'(burst_split), 32'(e.s));
    endtask

    task automatic send(input logic [DW-1:0] w, input int lane,
                        input logic s, input logic mw);
        exp_t e;
        valid_in  = 1'b1;
        data_in   = w;
        mode_word = mw;
        e.v = NC'(1) << lane;
        e.d = (NC*DW)'(w) << (lane * DW);
        e.s = s;
        sb.push_back(e);
        step();
    endtask

    task automatic idle(input logic mw);
        exp_t e;
        valid_in  = 1'b0;
        data_in   = '0;
        mode_word = mw;
        e.v = '0;
        e.d = '0;
        e.s = 1'b0;
        sb.push_back(e);
        step();
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_vout"}, 32'(valid_out), 32'd0);
        chk({tag, "_dout"}, data_out, 32'd0);
        chk({tag, "_lane"}, 32'(lane_idx), 32'd0);
        chk({tag, "_split"}, 32'(burst_split), 32'd0);
        valid_in = 1'b0;
        data_in  = '0;
        @(negedge clk_2f);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        mode_word = 1'b0;
        repeat (2) @(posedge clk_2f);
        #1;
        chk("rst_vout", 32'(valid_out), 32'd0);
        chk("rst_lane", 32'(lane_idx), 32'd0);
        @(negedge clk_2f);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk("idle_lane", 32'(lane_idx), 32'd0);
        end

        send(8'hA1, 0, 1'b0, 1'b0);
        send(8'hA2, 0, 1'b0, 1'b0);
        send(8'hA3, 0, 1'b0, 1'b0);
        chk("burst_hold", 32'(lane_idx), 32'd0);
        idle(1'b0);
        chk("burst1_end", 32'(lane_idx), 32'd1);
        idle(1'b0);
        chk("idle_noadv", 32'(lane_idx), 32'd1);
        send(8'hB1, 1, 1'b0, 1'b0);
        send(8'hB2, 1, 1'b0, 1'b0);
        idle(1'b0);
        chk("burst2_end", 32'(lane_idx), 32'd2);

        pulse_reset("rst_a");
        idle(1'b1);
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h10 + i), i % NC, 1'b0, 1'b1);
        end
        chk("word_end", 32'(lane_idx), 32'd2);
        idle(1'b0);
        chk("word_idle", 32'(lane_idx), 32'd2);

        for (int i = 0; i < 6; i++) begin
            send(8'(8'h30 + i), (i < MB) ? 2 : 3,
                 (i == MB - 1), 1'b0);
        end
        idle(1'b0);
        chk("split_end", 32'(lane_idx), 32'd0);
        idle(1'b0);
        chk("split_idle", 32'(lane_idx), 32'd0);

        send(8'h51, 0, 1'b0, 1'b0);
        send(8'h52, 0, 1'b0, 1'b1);
        send(8'h53, 0, 1'b0, 1'b1);
        chk("mode_frozen", 32'(lane_idx), 32'd0);
        idle(1'b1);
        chk("mode_bend", 32'(lane_idx), 32'd1);
        send(8'h61, 1, 1'b0, 1'b1);
        send(8'h62, 2, 1'b0, 1'b1);
        idle(1'b0);
        chk("mode_back", 32'(lane_idx), 32'd3);

        send(8'h71, 3, 1'b0, 1'b0);
        idle(1'b0);
        send(8'h72, 0, 1'b0, 1'b0);
        idle(1'b0);
        send(8'h73, 1, 1'b0, 1'b0);
        idle(1'b0);
        chk("pre_rst_lane", 32'(lane_idx), 32'd2);
        send(8'hC1, 2, 1'b0, 1'b0);
        valid_in = 1'b1;
        data_in  = 8'hC2;
        pulse_reset("rst_b");
        send(8'hD1, 0, 1'b0, 1'b0);
        send(8'hD2, 0, 1'b0, 1'b0);
        idle(1'b0);
        chk("post_rst_lane", 32'(lane_idx), 32'd1);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/demux_rr_n.md
Name: demux_rr_n

Overview:
- Parametrised 1:N demultiplexer for the phy receive path; next generation of the existing 1:2 valid-qualified demux.
- Steers a valid-qualified input word stream onto N_CH registered lanes using a round-robin lane pointer.
- Two modes:
  - Burst mode: advance lane after each valid burst.
  - Word mode: advance lane after every word.
- Forced lane split when a burst exceeds MAX_BURST words, plus lane/status outputs for the downstream unstriper/monitor.

Parameters:
- DATA_W, 8, width of each data word.
- N_CH, 4, number of output lanes (>=2).
- MAX_BURST, 16, max words per lane before forced advance in burst mode; 0 = unlimited.

Ports:
- clk_2f  input  1  single clock; all logic on posedge.
- reset  input  1  reset; asynchronous, active-high.
- valid_in  input  1  qualifies data_in this cycle.
- data_in  input  DATA_W  input word.
- mode_word  input  1  0 = burst mode, 1 = word mode; sampled only on idle cycles.
- data_out  output  N_CH*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- valid_out  output  N_CH  one-hot or zero; bit k = lane k valid.
- lane_idx  output  SEL_W  current lane pointer (SEL_W = max(1, clog2(N_CH))).
- burst_split  output  1  one-cycle pulse when MAX_BURST forced an advance.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - Async assert clears all state immediately: data_out=0, valid_out=0, lane_idx=0, burst_split=0, mode_q=0 (burst), word count=0, in_burst=0.
  - Deassertion is synchronised externally.
- Latency:
  - Exactly 1 cycle. Word accepted at edge t appears on lane lane_idx(t) at edge t+1.
  - Non-selected lanes drive data 0 and valid 0.
  - Cycles with valid_in=0 produce data_out=0, valid_out=0.
- Mode capture:
  - mode_q <= mode_word on every cycle with valid_in=0.
  - mode_q is frozen while valid_in=1, so the mode cannot change mid-burst.
  - A burst starting in the first cycle after reset uses burst mode.
- Lane pointer (wraps N_CH-1 -> 0), burst mode (mode_q=0):
  - Pointer holds while valid_in=1.
  - in_burst is set on an accepted word.
  - On the first cycle with valid_in=0 and in_burst=1, pointer advances by 1 and in_burst clears.
  - Idle cycles with in_burst=0 do not advance.
- Lane pointer, word mode (mode_q=1):
  - Pointer advances by 1 after every accepted word, including back-to-back words.
  - Idle cycles do not advance.
- Forced split (burst mode, MAX_BURST>0):
  - Word count increments per accepted word.
  - When the accepted word is the MAX_BURST-th: pointer advances at the same edge, count resets to 0, burst_split=1 for one cycle aligned with that word's output.
  - The next word goes to the next lane.
  - If valid_in then drops, no additional advance occurs, because in_burst is cleared by the split.
- Count handling:
  - Count resets on any idle cycle.
  - Count is unused in word mode and held at 0 there.
  - Counter width is clog2(MAX_BURST+1).
- Simultaneous events:
  - A split and the burst end in the same cycle cause a single advance.
  - Reset mid-burst discards the in-flight output word; lane_idx returns to 0.
- Arithmetic:
  - Pointer increment is modulo N_CH; N_CH need not be a power of 2.
  - No X on outputs after reset.

Decomposition:
- Package demux_pkg:
  - mode constants MODE_BURST=0, MODE_WORD=1;
  - function sel_w(n) returning max(1, clog2(n));
  - shared lane-pointer width helper.
- Sub-module rr_lane_ptr:
  - modulo-N_CH wrap counter with an advance input and async active-high reset;
  - reusable by the matching mux/unstriper.

Test Plan:
- Reset/idle, N_CH=4, DATA_W=8:
  - assert reset mid-cycle -> outputs 0 immediately, lane_idx=0.
  - release, hold valid_in=0 for 10 cycles -> lane_idx stays 0, valid_out=4'b0000.
- Burst mode, bursts of 3 words (0xA1,0xA2,0xA3), idle gap, then 2 words (0xB1,0xB2):
  - first burst on lane 0, valid_out=4'b0001 for 3 cycles, 1-cycle latency;
  - second burst on lane 1;
  - lane_idx reaches 2 after the second gap.
- Word mode, mode_word=1 during idle, then 6 back-to-back words 0x10..0x15:
  - lanes 0,1,2,3,0,1; valid_out walks 0001,0010,0100,1000,0001,0010.
- Forced split, MAX_BURST=4, one 6-word burst:
  - words 1-4 on lane 0, words 5-6 on lane 1;
  - burst_split=1 only in the output cycle of word 4;
  - after valid_in drops, lane_idx=2.
- Mode stability: toggle mode_word 0->1 while valid_in=1 mid-burst -> burst stays on one lane; word mode takes effect only after the next idle cycle.
- Reset mid-burst on lane 2 -> lane_idx=0 at once; next burst lands on lane 0 with no stale data.
